// File: rtl/multdiv_sequencer.sv
// ============================================================================
// Module      : multdiv_sequencer
// Description : Execute-stage controller that issues mult/div ops to the shared
//               multdiv unit, buffers the result and arbitrates it into the
//               single regfile writeback port; also raises RAW/structural stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_sequencer #(
    parameter int          TIMEOUT_CYCLES = 40,
    parameter logic [4:0]  STATUS_REG     = 5'd30,
    parameter logic [31:0] STATUS_MULT    = 32'd4,
    parameter logic [31:0] STATUS_DIV     = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        issue_stall,
    input  logic [4:0]  dep_rs,
    input  logic [4:0]  dep_rt,
    output logic        dep_stall,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_data_a,
    output logic [31:0] md_data_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    input  logic        wb_pipe_valid,
    output logic        wb_take,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        timeout_flag
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [4:0]    r_rd;
    logic          r_is_div;
    logic [31:0]   r_result;
    logic          r_exc;
    logic          r_exc_div;

    logic          w_take;
    logic          w_accept;
    logic [4:0]    w_rd_eff;
    logic          w_pending_hit;
    logic          w_issue_hit;

    // The pipeline always wins the writeback port; we only retire into idle slots.
    assign w_take   = (r_state == S_DONE) && !wb_pipe_valid;
    assign w_accept = issue_valid && ((r_state == S_IDLE) || w_take);

    // Once an exception result is waiting, the register it will write is $rstatus.
    assign w_rd_eff      = ((r_state == S_DONE) && r_exc) ? STATUS_REG : r_rd;
    assign w_pending_hit = (r_state != S_IDLE) && (w_rd_eff != 5'd0) &&
                           ((dep_rs == w_rd_eff) || (dep_rt == w_rd_eff));
    assign w_issue_hit   = (r_state == S_IDLE) && issue_valid && (issue_rd != 5'd0) &&
                           ((dep_rs == issue_rd) || (dep_rt == issue_rd));

    assign issue_stall = issue_valid && (r_state != S_IDLE) && !w_take;
    assign dep_stall   = w_pending_hit || w_issue_hit;

    assign wb_take = w_take;
    assign wb_reg  = !w_take ? 5'd0  : (r_exc ? STATUS_REG : r_rd);
    assign wb_data = !w_take ? 32'd0 :
                     (r_exc ? (r_exc_div ? STATUS_DIV : STATUS_MULT) : r_result);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_rd         <= 5'd0;
            r_is_div     <= 1'b0;
            r_result     <= 32'd0;
            r_exc        <= 1'b0;
            r_exc_div    <= 1'b0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            md_data_a    <= 32'd0;
            md_data_b    <= 32'd0;
            timeout_flag <= 1'b0;
        end else begin
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                end
                S_START: begin
                    r_count <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_count <= r_count + CW'(1);
                    if (md_ready) begin
                        r_result  <= md_result;
                        r_exc     <= md_exception;
                        r_exc_div <= r_is_div;
                        r_state   <= S_DONE;
                    end else if (r_count == C_LAST_COUNT) begin
                        r_exc        <= 1'b1;
                        r_exc_div    <= 1'b1;
                        timeout_flag <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_take) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Acceptance overrides the retire transition so a new op can
            // enter in the same cycle the previous result leaves.
            if (w_accept) begin
                r_state      <= S_START;
                r_rd         <= issue_rd;
                r_is_div     <= issue_is_div;
                r_exc        <= 1'b0;
                md_data_a    <= issue_a;
                md_data_b    <= issue_b;
                md_ctrl_mult <= !issue_is_div;
                md_ctrl_div  <= issue_is_div;
            end
        end
    end

endmodule

`default_nettype wire
